// File: rtl/alu_exec_unit_if.sv
// Handshake bus for the execute-stage ALU: operation request from decode,
// result and flags back to writeback.
interface alu_exec_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUOp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] R;
    logic        ALUz;
    logic        V;
    logic        C;
    logic        err;

    modport master (
        output in_valid, A, B, ALUOp, out_ready,
        input  in_ready, out_valid, R, ALUz, V, C, err
    );

    modport slave (
        input  in_valid, A, B, ALUOp, out_ready,
        output in_ready, out_valid, R, ALUz, V, C, err
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Non-pipelined execute ALU: single-cycle logic/arith ops, iterative one-bit-per-cycle
// shifter for SLL/SRL/SRA, result held until writeback accepts it.
module alu_exec_unit (
    input logic            clk,
    input logic            rst,
    alu_exec_unit_if.slave bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  op_reg, op_next;
    logic [31:0] sh_reg, sh_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [31:0] r_reg, r_next;
    logic        z_reg, z_next;
    logic        v_reg, v_next;
    logic        c_reg, c_next;
    logic        err_reg, err_next;

    // Single-cycle datapath, evaluated on the operands presented in IDLE.
    logic [31:0] b_op;
    logic [32:0] sum;
    logic [31:0] alu_r;
    logic        alu_v, alu_c, alu_err, is_shift;

    always_comb begin
        b_op    = (bus.ALUOp == OP_SUB) ? ~bus.B : bus.B;
        sum     = {1'b0, bus.A} + {1'b0, b_op} + {32'd0, (bus.ALUOp == OP_SUB)};
        alu_r   = '0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        alu_err = 1'b0;
        case (bus.ALUOp)
            OP_AND: alu_r = bus.A & bus.B;
            OP_OR:  alu_r = bus.A | bus.B;
            OP_NOR: alu_r = ~(bus.A | bus.B);
            OP_ADD: begin
                alu_r = sum[31:0];
                alu_c = sum[32];
                alu_v = (bus.A[31] == bus.B[31]) && (sum[31] != bus.A[31]);
            end
            OP_SUB: begin
                alu_r = sum[31:0];
                alu_c = sum[32];
                alu_v = (bus.A[31] != bus.B[31]) && (sum[31] != bus.A[31]);
            end
            OP_SLT: alu_r = {31'd0, ($signed(bus.A) < $signed(bus.B))};
            OP_SLL, OP_SRL, OP_SRA: alu_r = '0;
            default: alu_err = 1'b1;
        endcase
    end

    assign is_shift = (bus.ALUOp == OP_SLL) || (bus.ALUOp == OP_SRL) || (bus.ALUOp == OP_SRA);

    // One-bit shift step of the shift register for each direction.
    logic [31:0] sll1, srl1, sra1, step;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_step
            if (gi == 0) begin : g_lo
                assign sll1[gi] = 1'b0;
            end else begin : g_lo
                assign sll1[gi] = sh_reg[gi-1];
            end
            if (gi == 31) begin : g_hi
                assign srl1[gi] = 1'b0;
                assign sra1[gi] = sh_reg[31];
            end else begin : g_hi
                assign srl1[gi] = sh_reg[gi+1];
                assign sra1[gi] = sh_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        case (op_reg)
            OP_SLL:  step = sll1;
            OP_SRL:  step = srl1;
            default: step = sra1;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        sh_next    = sh_reg;
        cnt_next   = cnt_reg;
        r_next     = r_reg;
        z_next     = z_reg;
        v_next     = v_reg;
        c_next     = c_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    op_next = bus.ALUOp;
                    if (is_shift && (bus.B[4:0] == 5'd0)) begin
                        r_next     = bus.A;
                        z_next     = (bus.A == 32'd0);
                        v_next     = 1'b0;
                        c_next     = 1'b0;
                        err_next   = 1'b0;
                        state_next = DONE;
                    end else if (is_shift) begin
                        sh_next    = bus.A;
                        cnt_next   = bus.B[4:0];
                        state_next = SHIFT;
                    end else begin
                        r_next     = alu_r;
                        z_next     = !alu_err && (alu_r == 32'd0);
                        v_next     = alu_v;
                        c_next     = alu_c;
                        err_next   = alu_err;
                        state_next = DONE;
                    end
                end
            end
            SHIFT: begin
                sh_next  = step;
                cnt_next = cnt_reg - 5'd1;
                // The last step goes straight to R so the result is ready on the same edge.
                if (cnt_reg == 5'd1) begin
                    r_next     = step;
                    z_next     = (step == 32'd0);
                    v_next     = 1'b0;
                    c_next     = 1'b0;
                    err_next   = 1'b0;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            sh_reg    <= '0;
            cnt_reg   <= '0;
            r_reg     <= '0;
            z_reg     <= 1'b0;
            v_reg     <= 1'b0;
            c_reg     <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            sh_reg    <= sh_next;
            cnt_reg   <= cnt_next;
            r_reg     <= r_next;
            z_reg     <= z_next;
            v_reg     <= v_next;
            c_reg     <= c_next;
            err_reg   <= err_next;
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.R         = r_reg;
    assign bus.ALUz      = z_reg;
    assign bus.V         = v_reg;
    assign bus.C         = c_reg;
    assign bus.err       = err_reg;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver queues expected results on accept,
// an independent monitor checks them (values, latency, stability) when they appear.
module tb_alu_exec_unit;
    logic clk;
    logic rst;
    alu_exec_unit_if bus ();

    alu_exec_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [31:0] r;
        logic        z, v, c, e;
        int          lat;
        int          acc;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   pop_cyc = 0;
    int   n_issued = 0;
    int   n_done = 0;
    bit   rnd_mode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_mode) bus.out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: first appearance checks values and latency; handshake checks stability and pops.
    initial begin
        bit          seen;
        bit          stable;
        logic [35:0] held;
        exp_t        cur;
        seen = 0;
        stable = 1;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
            end else begin
                if (bus.out_valid && !seen) begin
                    seen   = 1;
                    stable = 1;
                    held   = {bus.R, bus.ALUz, bus.V, bus.C, bus.err};
                    checks++;
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL spurious_result: R=%h with nothing outstanding", bus.R);
                    end else begin
                        cur = q[0];
                        if ({bus.R, bus.ALUz, bus.V, bus.C, bus.err} !== {cur.r, cur.z, cur.v, cur.c, cur.e}) begin
                            failures++;
                            $display("FAIL %s: got R=%h z=%b v=%b c=%b err=%b, expected R=%h z=%b v=%b c=%b err=%b",
                                     cur.nm, bus.R, bus.ALUz, bus.V, bus.C, bus.err,
                                     cur.r, cur.z, cur.v, cur.c, cur.e);
                        end
                        checks++;
                        if (cyc - cur.acc != cur.lat) begin
                            failures++;
                            $display("FAIL %s_latency: got %0d cycles, expected %0d", cur.nm, cyc - cur.acc, cur.lat);
                        end
                    end
                end else if (bus.out_valid && seen) begin
                    if ({bus.R, bus.ALUz, bus.V, bus.C, bus.err} !== held) stable = 0;
                end
                if (bus.out_valid && bus.out_ready) begin
                    checks++;
                    if (!stable) begin
                        failures++;
                        $display("FAIL result_stable: outputs changed while held, now R=%h, first R=%h", bus.R, held[35:4]);
                    end
                    if (q.size() != 0) begin
                        void'(q.pop_front());
                        n_done++;
                    end
                    pop_cyc = cyc;
                    seen = 0;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic [31:0] er, input logic ez, input logic ev, input logic ec,
                         input logic ee, input int elat, input string nm, input bit push);
        bit   ok;
        exp_t e;
        bus.A = a;
        bus.B = b;
        bus.ALUOp = op;
        bus.in_valid = 1'b1;
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.in_ready && !rst) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_accept: in_ready=%b after 300 cycles, expected 1", nm, bus.in_ready);
        end else begin
            last_acc = cyc;
            if (push) begin
                e.r = er; e.z = ez; e.v = ev; e.c = ec; e.e = ee;
                e.lat = elat; e.acc = cyc; e.nm = nm;
                q.push_back(e);
                n_issued++;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        bit ok;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_drain: %0d results outstanding, expected 0", nm, q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    // Independent reference for the random phase.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        exp_t        e;
        logic [32:0] s;
        e.r = '0; e.z = 0; e.v = 0; e.c = 0; e.e = 0; e.lat = 1; e.acc = 0; e.nm = "random";
        case (op)
            4'd0:  e.r = a & b;
            4'd1:  e.r = a | b;
            4'd12: e.r = ~(a | b);
            4'd2: begin
                s = {1'b0, a} + {1'b0, b};
                e.r = s[31:0];
                e.c = s[32];
                e.v = (a[31] == b[31]) && (e.r[31] != a[31]);
            end
            4'd6: begin
                s = {1'b0, a} - {1'b0, b};
                e.r = s[31:0];
                e.c = (a >= b);
                e.v = (a[31] != b[31]) && (e.r[31] != a[31]);
            end
            4'd7: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3: begin e.r = a << b[4:0]; e.lat = int'(b[4:0]) + 1; end
            4'd4: begin e.r = a >> b[4:0]; e.lat = int'(b[4:0]) + 1; end
            4'd5: begin e.r = $signed(a) >>> b[4:0]; e.lat = int'(b[4:0]) + 1; end
            default: e.e = 1;
        endcase
        e.z = !e.e && (e.r == 32'd0);
        return e;
    endfunction

    initial begin
        logic [3:0] legal [9];
        logic [31:0] ra, rb;
        logic [3:0]  rop;
        exp_t        m;
        bit          bp_ok;
        legal = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12};

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.ALUOp = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_R", bus.R, 32'd0);
        chk("reset_flags", {28'd0, bus.ALUz, bus.V, bus.C, bus.err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors: a, b, op, R, z, v, c, err, latency
        issue(32'h7FFFFFFF, 32'h1, 4'd2, 32'h80000000, 0, 1, 0, 0, 1, "add_ovf", 1);          drain("add_ovf");
        issue(32'hFFFFFFFF, 32'h1, 4'd2, 32'h0, 1, 0, 1, 0, 1, "add_carry", 1);               drain("add_carry");
        issue(32'd5, 32'd5, 4'd6, 32'h0, 1, 0, 1, 0, 1, "sub_eq", 1);                         drain("sub_eq");
        issue(32'h80000000, 32'h1, 4'd6, 32'h7FFFFFFF, 0, 1, 1, 0, 1, "sub_ovf", 1);          drain("sub_ovf");
        issue(32'd3, 32'd5, 4'd6, 32'hFFFFFFFE, 0, 0, 0, 0, 1, "sub_borrow", 1);              drain("sub_borrow");
        issue(32'hFFFFFFFD, 32'd2, 4'd7, 32'h1, 0, 0, 0, 0, 1, "slt_true", 1);                drain("slt_true");
        issue(32'd2, 32'hFFFFFFFD, 4'd7, 32'h0, 1, 0, 0, 0, 1, "slt_false", 1);               drain("slt_false");
        issue(32'h0, 32'h0, 4'd12, 32'hFFFFFFFF, 0, 0, 0, 0, 1, "nor_zero", 1);               drain("nor_zero");
        issue(32'hF0F0F0F0, 32'h0F0F0F0F, 4'd0, 32'h0, 1, 0, 0, 0, 1, "and_disjoint", 1);     drain("and_disjoint");
        issue(32'h12340000, 32'h00005678, 4'd1, 32'h12345678, 0, 0, 0, 0, 1, "or_merge", 1);  drain("or_merge");
        issue(32'h1234, 32'h5678, 4'd15, 32'h0, 0, 0, 0, 1, 1, "illegal_f", 1);               drain("illegal_f");
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd8, 32'h0, 0, 0, 0, 1, 1, "illegal_8", 1);        drain("illegal_8");
        issue(32'h80000000, 32'd31, 4'd5, 32'hFFFFFFFF, 0, 0, 0, 0, 32, "sra_31", 1);         drain("sra_31");
        issue(32'h80000000, 32'd31, 4'd4, 32'h1, 0, 0, 0, 0, 32, "srl_31", 1);                drain("srl_31");
        issue(32'd3, 32'd0, 4'd3, 32'h3, 0, 0, 0, 0, 1, "sll_0", 1);                          drain("sll_0");
        issue(32'd1, 32'h25, 4'd3, 32'h20, 0, 0, 0, 0, 6, "sll_5", 1);                        drain("sll_5");
        issue(32'h80000000, 32'd4, 4'd5, 32'hF8000000, 0, 0, 0, 0, 5, "sra_4", 1);            drain("sra_4");
        issue(32'h000000F0, 32'd4, 4'd4, 32'h0000000F, 0, 0, 0, 0, 5, "srl_4", 1);            drain("srl_4");

        // Reset in the middle of a 20-step shift discards it.
        issue(32'd1, 32'd20, 4'd3, 32'h0, 0, 0, 0, 0, 21, "sll_aborted", 0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("abort_R", bus.R, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(32'd2, 32'd3, 4'd2, 32'd5, 0, 0, 0, 0, 1, "add_after_abort", 1);                drain("add_after_abort");

        // Backpressure: the next op waits while the held result is not consumed.
        bus.out_ready = 1'b0;
        issue(32'd10, 32'd20, 4'd2, 32'd30, 0, 0, 0, 0, 1, "add_held", 1);
        fork
            issue(32'd7, 32'd2, 4'd6, 32'd5, 0, 0, 1, 0, 1, "sub_after_bp", 1);
            begin
                bp_ok = 1;
                repeat (10) begin
                    @(negedge clk);
                    if (bus.in_ready || !bus.out_valid) bp_ok = 0;
                end
                chk("bp_blocked", {31'd0, bp_ok}, 32'd1);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        chk("bp_accept_next_cycle", 32'(last_acc - pop_cyc), 32'd1);
        drain("sub_after_bp");

        // Random phase with random consumer backpressure.
        rnd_mode = 1;
        for (int i = 0; i < 100; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 9) == 0) rop = 4'($urandom_range(0, 15));
            else rop = legal[$urandom_range(0, 8)];
            if ($urandom_range(0, 7) == 0) rb = ra;
            m = model(ra, rb, rop);
            issue(ra, rb, rop, m.r, m.z, m.v, m.c, m.e, m.lat, "random", 1);
        end
        rnd_mode = 0;
        #2;
        bus.out_ready = 1'b1;
        drain("random");

        chk("ops_not_lost_or_duplicated", 32'(n_done), 32'(n_issued));
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
